vend_keypad_fsm: RTL and testbench
==================================

Name: vend_keypad_fsm

Overview:
Parametrised successor to the keypad-driven vending FSM. Scans an active-low row/column keypad and debounces it. Runs the full purchase flow: item select, price view, quantity entry, total view, amount entry, then vend or refund. It sits between the keypad pins and the display/dispense logic. Price lookup is external, through item_sel/price_in.

Parameters:
ROWS, 4, keypad rows (width of r)
COLS, 4, keypad columns (width of c)
NUM_ITEMS, 8, number of selectable items (digit keys 0..NUM_ITEMS-1)
PRICE_W, 8, price width
QTY_W, 4, quantity register width
MAX_QTY, 15, largest accepted quantity (must be at most 2^QTY_W-1)
AMT_W, 12, width of total, amount and change (must be at least PRICE_W+QTY_W)
DEBOUNCE, 3, consecutive stable cycles required for a key event
KEY_OK, 10, key code for confirm
KEY_CANCEL, 11, key code for cancel

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
c  in  COLS  column lines, active-low, all-ones means idle
r  in  ROWS  row lines, active-low, all-ones means idle
price_in  in  PRICE_W  price of item_sel, from external table, combinational
item_sel  out  clog2(NUM_ITEMS)  currently selected item
view_price  out  1  state PRICE
view_quantity  out  1  state QTY
view_price_q  out  1  state TOTAL
entered_amount  out  1  state PAY
qty  out  QTY_W  entered quantity
total  out  AMT_W  price times quantity
amount  out  AMT_W  entered payment
change  out  AMT_W  change or refund, valid with vend/refund
vend  out  1  one-cycle dispense pulse
refund  out  1  one-cycle refund pulse
short  out  1  one-cycle "insufficient amount" pulse

Behaviour:
- Reset low: state IDLE; all outputs 0; debouncer cleared and armed.
- Key decode: valid only when exactly one bit of r is 0 and exactly one bit of c is 0.
- Key code = row_index*COLS + col_index, where bit 0 is index 0.
- Codes 0..9 are digits. KEY_OK and KEY_CANCEL are commands. All other codes are ignored.
- Multi-key or partial patterns count as bounce: they clear the stability counter.
- Debounce: the same valid code sampled on DEBOUNCE consecutive edges raises one internal event at the DEBOUNCE-th edge.
- The FSM acts on the next edge: state and outputs change at edge DEBOUNCE+1 after first sample.
- After an event, no new event until r or c is all-ones for DEBOUNCE consecutive edges. No auto-repeat.
- Flag outputs are Moore decodes of the registered state. Pulses are registered and last exactly one cycle.
- IDLE: digit d < NUM_ITEMS → item_sel=d, go to PRICE. Other keys ignored.
- PRICE: valid digit → reselect, stay. OK → latch price_in, qty=0, go to QTY. CANCEL → IDLE.
- QTY: digit d → qty = qty*10+d, only if the result ≤ MAX_QTY; otherwise the digit is dropped.
- QTY: OK with qty=0 ignored. OK otherwise → total = price×qty (full width), go to TOTAL. CANCEL → IDLE, qty=0.
- TOTAL: OK → amount=0, go to PAY. CANCEL → IDLE.
- PAY: digit → amount = amount*10+d, only if the result fits in AMT_W; otherwise dropped.
- PAY: OK with amount ≥ total → change = amount−total, go to VEND.
- PAY: OK with amount < total → short pulse, stay in PAY, amount kept.
- PAY: CANCEL → change=amount, refund pulse, go to IDLE.
- VEND: vend=1 for one cycle, then IDLE. change holds until the next transaction leaves IDLE.
- Returning to IDLE clears qty, total and amount. item_sel and change hold.
- Reset asserted mid-transaction aborts immediately. No vend or refund pulse is issued.

Test Plan:
1. Reset low for 100 ns, then high with r=c=4'b1111 → IDLE, all flags and pulses 0, no event.
2. Press row0/col3 (code 3) for 3 cycles → view_price=1 and item_sel=3 at edge 4. Hold key 20 cycles → exactly one event. Release then press again → new event only after 3 idle cycles.
3. price_in=25, then keys OK,1,2,OK → qty=12, view_price_q=1, total=300. Keys 1,6 in QTY → qty=1 (16 > MAX_QTY is dropped).
4. In PAY, enter 2,9,9 then OK → short pulse, stay PAY. Enter 2,9,9 then 3 (amount 2993), OK → vend pulse, change=2693, then IDLE.
5. In PAY with amount=50, CANCEL → refund=1 for one cycle, change=50, IDLE, no vend.
6. r=4'b0011 or bounce toggling each cycle → no event. Reset asserted in QTY → IDLE, qty=0, no pulses.

Source files
------------

// File: rtl/vend_keypad_fsm_if.sv
// Keypad pins, external price lookup and display/dispense outputs of the vending FSM.
interface vend_keypad_fsm_if #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int NUM_ITEMS = 8,
  parameter int PRICE_W   = 8,
  parameter int QTY_W     = 4,
  parameter int AMT_W     = 12
);
  localparam int SEL_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;

  logic [COLS-1:0]    c;
  logic [ROWS-1:0]    r;
  logic [PRICE_W-1:0] price_in;
  logic [SEL_W-1:0]   item_sel;
  logic               view_price;
  logic               view_quantity;
  logic               view_price_q;
  logic               entered_amount;
  logic [QTY_W-1:0]   qty;
  logic [AMT_W-1:0]   total;
  logic [AMT_W-1:0]   amount;
  logic [AMT_W-1:0]   change;
  logic               vend;
  logic               refund;
  logic               short;

  // Keypad / price-table side
  modport master (
    output c, r, price_in,
    input  item_sel, view_price, view_quantity, view_price_q, entered_amount,
    input  qty, total, amount, change, vend, refund, short
  );

  // Vending controller side
  modport slave (
    input  c, r, price_in,
    output item_sel, view_price, view_quantity, view_price_q, entered_amount,
    output qty, total, amount, change, vend, refund, short
  );
endinterface

// File: rtl/vend_keypad_fsm.sv
// Keypad scanner with debounce feeding the vending purchase flow:
// item select -> price view -> quantity -> total view -> payment -> vend/refund.
module vend_keypad_fsm #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int NUM_ITEMS  = 8,
  parameter int PRICE_W    = 8,
  parameter int QTY_W      = 4,
  parameter int MAX_QTY    = 15,
  parameter int AMT_W      = 12,
  parameter int DEBOUNCE   = 3,
  parameter int KEY_OK     = 10,
  parameter int KEY_CANCEL = 11
) (
  input  logic             clk,
  input  logic             reset,
  vend_keypad_fsm_if.slave kp
);

  localparam int SEL_W  = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
  localparam int RIDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CIDX_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CODE_W = ($clog2(ROWS*COLS) < 4) ? 4 : $clog2(ROWS*COLS);
  localparam int CNT_W  = $clog2(DEBOUNCE + 1);
  localparam int QX_W   = QTY_W + 4;
  localparam int AX_W   = AMT_W + 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRICE,
    S_QTY,
    S_TOTAL,
    S_PAY,
    S_VEND
  } state_t;

  // Keypad decode
  logic              key_valid;
  logic              key_idle;
  logic [RIDX_W-1:0] r_idx;
  logic [CIDX_W-1:0] c_idx;
  logic [CODE_W-1:0] key_code;

  // Debouncer state
  logic              armed_q, armed_d;
  logic [CNT_W-1:0]  stab_cnt_q, stab_cnt_d;
  logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic [CODE_W-1:0] last_code_q, last_code_d;
  logic              ev_q, ev_d;
  logic [CODE_W-1:0] ev_code_q, ev_code_d;

  // Purchase flow state
  state_t             state_q, state_d;
  logic [SEL_W-1:0]   item_sel_q, item_sel_d;
  logic [PRICE_W-1:0] price_q, price_d;
  logic [QTY_W-1:0]   qty_q, qty_d;
  logic [AMT_W-1:0]   total_q, total_d;
  logic [AMT_W-1:0]   amount_q, amount_d;
  logic [AMT_W-1:0]   change_q, change_d;
  logic               vend_q, vend_d;
  logic               refund_q, refund_d;
  logic               short_q, short_d;

  logic              is_digit;
  logic              is_item;
  logic              is_ok;
  logic              is_cancel;
  logic [3:0]        digit;
  logic [QX_W-1:0]   qty_ext;
  logic [AX_W-1:0]   amt_ext;

  // Decode the active-low matrix: a key is valid only with exactly one row and one column low
  always_comb begin
    r_idx = '0;
    c_idx = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (!kp.r[i]) r_idx = RIDX_W'(i);
    end
    for (int j = 0; j < COLS; j++) begin
      if (!kp.c[j]) c_idx = CIDX_W'(j);
    end
    key_valid = ($countones(~kp.r) == 1) && ($countones(~kp.c) == 1);
    key_idle  = (&kp.r) | (&kp.c);
    key_code  = CODE_W'(r_idx) * CODE_W'(COLS) + CODE_W'(c_idx);
  end

  // Debounce: one event per press, re-armed only after a stable release
  always_comb begin
    armed_d     = armed_q;
    stab_cnt_d  = stab_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    last_code_d = last_code_q;
    ev_d        = 1'b0;
    ev_code_d   = ev_code_q;
    if (armed_q) begin
      idle_cnt_d = '0;
      if (key_valid) begin
        if ((stab_cnt_q != '0) && (key_code == last_code_q)) begin
          stab_cnt_d = stab_cnt_q + CNT_W'(1);
        end else begin
          stab_cnt_d = CNT_W'(1);
        end
        last_code_d = key_code;
        if (stab_cnt_d == CNT_W'(DEBOUNCE)) begin
          ev_d       = 1'b1;
          ev_code_d  = key_code;
          armed_d    = 1'b0;
          stab_cnt_d = '0;
        end
      end else begin
        // Idle, multi-key and partial patterns all break stability
        stab_cnt_d = '0;
      end
    end else begin
      stab_cnt_d = '0;
      if (key_idle) begin
        idle_cnt_d = idle_cnt_q + CNT_W'(1);
        if (idle_cnt_d == CNT_W'(DEBOUNCE)) begin
          armed_d    = 1'b1;
          idle_cnt_d = '0;
        end
      end else begin
        idle_cnt_d = '0;
      end
    end
  end

  // Debouncer registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed_q     <= 1'b1;
      stab_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      last_code_q <= '0;
      ev_q        <= 1'b0;
      ev_code_q   <= '0;
    end else begin
      armed_q     <= armed_d;
      stab_cnt_q  <= stab_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      last_code_q <= last_code_d;
      ev_q        <= ev_d;
      ev_code_q   <= ev_code_d;
    end
  end

  // Purchase flow next-state and datapath updates driven by debounced key events
  always_comb begin
    state_d    = state_q;
    item_sel_d = item_sel_q;
    price_d    = price_q;
    qty_d      = qty_q;
    total_d    = total_q;
    amount_d   = amount_q;
    change_d   = change_q;
    vend_d     = 1'b0;
    refund_d   = 1'b0;
    short_d    = 1'b0;
    is_digit   = (ev_code_q < CODE_W'(10));
    is_item    = is_digit && (ev_code_q < CODE_W'(NUM_ITEMS));
    is_ok      = (ev_code_q == CODE_W'(KEY_OK));
    is_cancel  = (ev_code_q == CODE_W'(KEY_CANCEL));
    digit      = ev_code_q[3:0];
    // Widened accumulators so an overflowing digit can be detected and dropped
    qty_ext    = QX_W'(qty_q) * QX_W'(10) + QX_W'(digit);
    amt_ext    = AX_W'(amount_q) * AX_W'(10) + AX_W'(digit);
    case (state_q)
      S_IDLE: begin
        if (ev_q && is_item) begin
          item_sel_d = SEL_W'(ev_code_q);
          change_d   = '0;
          state_d    = S_PRICE;
        end
      end
      S_PRICE: begin
        if (ev_q) begin
          if (is_item) begin
            item_sel_d = SEL_W'(ev_code_q);
          end else if (is_ok) begin
            price_d = kp.price_in;
            qty_d   = '0;
            state_d = S_QTY;
          end else if (is_cancel) begin
            state_d = S_IDLE;
          end
        end
      end
      S_QTY: begin
        if (ev_q) begin
          if (is_digit) begin
            if (qty_ext <= QX_W'(MAX_QTY)) qty_d = qty_ext[QTY_W-1:0];
          end else if (is_ok) begin
            if (qty_q != '0) begin
              total_d = AMT_W'(price_q) * AMT_W'(qty_q);
              state_d = S_TOTAL;
            end
          end else if (is_cancel) begin
            state_d = S_IDLE;
          end
        end
      end
      S_TOTAL: begin
        if (ev_q) begin
          if (is_ok) begin
            amount_d = '0;
            state_d  = S_PAY;
          end else if (is_cancel) begin
            state_d = S_IDLE;
          end
        end
      end
      S_PAY: begin
        if (ev_q) begin
          if (is_digit) begin
            if (amt_ext[AX_W-1:AMT_W] == '0) amount_d = amt_ext[AMT_W-1:0];
          end else if (is_ok) begin
            if (amount_q >= total_q) begin
              change_d = amount_q - total_q;
              vend_d   = 1'b1;
              state_d  = S_VEND;
            end else begin
              short_d = 1'b1;
            end
          end else if (is_cancel) begin
            change_d = amount_q;
            refund_d = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end
      S_VEND: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Every return to IDLE drops the transaction data; item_sel and change survive
    if ((state_d == S_IDLE) && (state_q != S_IDLE)) begin
      qty_d    = '0;
      total_d  = '0;
      amount_d = '0;
    end
  end

  // Purchase flow registers; reset aborts without issuing any pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      item_sel_q <= '0;
      price_q    <= '0;
      qty_q      <= '0;
      total_q    <= '0;
      amount_q   <= '0;
      change_q   <= '0;
      vend_q     <= 1'b0;
      refund_q   <= 1'b0;
      short_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      item_sel_q <= item_sel_d;
      price_q    <= price_d;
      qty_q      <= qty_d;
      total_q    <= total_d;
      amount_q   <= amount_d;
      change_q   <= change_d;
      vend_q     <= vend_d;
      refund_q   <= refund_d;
      short_q    <= short_d;
    end
  end

  assign kp.view_price     = (state_q == S_PRICE);
  assign kp.view_quantity  = (state_q == S_QTY);
  assign kp.view_price_q   = (state_q == S_TOTAL);
  assign kp.entered_amount = (state_q == S_PAY);
  assign kp.item_sel       = item_sel_q;
  assign kp.qty            = qty_q;
  assign kp.total          = total_q;
  assign kp.amount         = amount_q;
  assign kp.change         = change_q;
  assign kp.vend           = vend_q;
  assign kp.refund         = refund_q;
  assign kp.short          = short_q;

endmodule

// File: tb/tb_vend_keypad_fsm.sv
// Bench for vend_keypad_fsm: directed scenarios plus a randomized key stream
// checked against a purchase-flow model.
module tb_vend_keypad_fsm;
  localparam int ROWS = 4, COLS = 4, NUM_ITEMS = 8, PRICE_W = 8, QTY_W = 4;
  localparam int MAX_QTY = 15, AMT_W = 12, DEBOUNCE = 3, KEY_OK = 10, KEY_CANCEL = 11;
  localparam int SEL_W = $clog2(NUM_ITEMS);
  localparam int P_IDLE = 0, P_PRICE = 1, P_QTY = 2, P_TOTAL = 3, P_PAY = 4, P_VEND = 5;

  logic clk = 1'b0;
  logic reset;
  int   total_cnt = 0;
  int   bad_cnt = 0;
  logic [PRICE_W-1:0] price_tab [NUM_ITEMS];

  int m_phase, m_item, m_price, m_qty, m_total, m_amount, m_change;
  bit e_vend, e_refund, e_short;

  vend_keypad_fsm_if #(.ROWS(ROWS), .COLS(COLS), .NUM_ITEMS(NUM_ITEMS), .PRICE_W(PRICE_W),
                       .QTY_W(QTY_W), .AMT_W(AMT_W)) bus ();

  vend_keypad_fsm #(.ROWS(ROWS), .COLS(COLS), .NUM_ITEMS(NUM_ITEMS), .PRICE_W(PRICE_W),
                    .QTY_W(QTY_W), .MAX_QTY(MAX_QTY), .AMT_W(AMT_W), .DEBOUNCE(DEBOUNCE),
                    .KEY_OK(KEY_OK), .KEY_CANCEL(KEY_CANCEL)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (bus)
  );

  always #5 clk = ~clk;

  // External price table, combinational on item_sel
  assign bus.price_in = price_tab[bus.item_sel];

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic key_on(input int code);
    bus.r = ~(ROWS'(1) << (code / COLS));
    bus.c = ~(COLS'(1) << (code % COLS));
  endtask

  task automatic keys_off();
    bus.r = '1;
    bus.c = '1;
  endtask

  // Clean press: event lands at edge DEBOUNCE+1, then a release long enough to re-arm
  task automatic push(input int code);
    key_on(code);
    edges(DEBOUNCE + 1);
    keys_off();
    edges(DEBOUNCE);
  endtask

  task automatic goto_pay();
    push(3); push(KEY_OK); push(1); push(2); push(KEY_OK); push(KEY_OK);
  endtask

  task automatic model_idle();
    m_phase = P_IDLE; m_qty = 0; m_total = 0; m_amount = 0;
  endtask

  // Purchase rules applied to one debounced key
  task automatic model_key(input int code);
    e_vend = 0; e_refund = 0; e_short = 0;
    case (m_phase)
      P_IDLE: if (code < 10 && code < NUM_ITEMS) begin
        m_item = code; m_change = 0; m_phase = P_PRICE;
      end
      P_PRICE: begin
        if (code < 10 && code < NUM_ITEMS) m_item = code;
        else if (code == KEY_OK) begin m_price = int'(price_tab[m_item]); m_qty = 0; m_phase = P_QTY; end
        else if (code == KEY_CANCEL) model_idle();
      end
      P_QTY: begin
        if (code < 10) begin
          if (m_qty * 10 + code <= MAX_QTY) m_qty = m_qty * 10 + code;
        end else if (code == KEY_OK) begin
          if (m_qty != 0) begin m_total = m_price * m_qty; m_phase = P_TOTAL; end
        end else if (code == KEY_CANCEL) model_idle();
      end
      P_TOTAL: begin
        if (code == KEY_OK) begin m_amount = 0; m_phase = P_PAY; end
        else if (code == KEY_CANCEL) model_idle();
      end
      P_PAY: begin
        if (code < 10) begin
          if (m_amount * 10 + code < (1 << AMT_W)) m_amount = m_amount * 10 + code;
        end else if (code == KEY_OK) begin
          if (m_amount >= m_total) begin m_change = m_amount - m_total; e_vend = 1; m_phase = P_VEND; end
          else e_short = 1;
        end else if (code == KEY_CANCEL) begin
          m_change = m_amount; e_refund = 1; model_idle();
        end
      end
      default: ;
    endcase
  endtask

  task automatic model_settle();
    if (m_phase == P_VEND) model_idle();
    e_vend = 0; e_refund = 0; e_short = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    keys_off();
    for (int i = 0; i < NUM_ITEMS; i++) price_tab[i] = PRICE_W'(10 + i);
    price_tab[3] = 8'd25;
    #100;
    total_cnt++;
    if ({bus.view_price, bus.view_quantity, bus.view_price_q, bus.entered_amount,
         bus.vend, bus.refund, bus.short} !== 7'b0) begin
      bad_cnt++; $display("FAIL rst_flags got=%b exp=0", {bus.view_price, bus.view_quantity,
        bus.view_price_q, bus.entered_amount, bus.vend, bus.refund, bus.short});
    end
    total_cnt++;
    if (bus.item_sel !== '0 || bus.qty !== '0 || bus.total !== '0 || bus.amount !== '0 || bus.change !== '0) begin
      bad_cnt++; $display("FAIL rst_regs got sel=%0d qty=%0d tot=%0d amt=%0d chg=%0d exp=all 0",
        bus.item_sel, bus.qty, bus.total, bus.amount, bus.change);
    end
    @(negedge clk); reset = 1'b1;
    edges(5);
    total_cnt++;
    if ({bus.view_price, bus.view_quantity, bus.view_price_q, bus.entered_amount} !== 4'b0) begin
      bad_cnt++; $display("FAIL rst_idle flags got=%b exp=0000", {bus.view_price, bus.view_quantity,
        bus.view_price_q, bus.entered_amount});
    end
  endtask

  task automatic test_debounce();
    key_on(3);
    edges(DEBOUNCE);
    total_cnt++;
    if (bus.view_price !== 1'b0) begin bad_cnt++; $display("FAIL deb_early view_price got=%b exp=0", bus.view_price); end
    edges(1);
    total_cnt++;
    if (bus.view_price !== 1'b1 || bus.item_sel !== 3'd3) begin
      bad_cnt++; $display("FAIL deb_event got view=%b sel=%0d exp view=1 sel=3", bus.view_price, bus.item_sel);
    end
    edges(20);
    keys_off(); edges(DEBOUNCE);
    // Single-cycle bounce on a key never accumulates
    for (int i = 0; i < 10; i++) begin key_on(5); edges(1); keys_off(); edges(1); end
    // Alternating keys restart the count
    for (int i = 0; i < 10; i++) begin key_on(5 + (i % 2)); edges(1); end
    // Two rows low at once is not a key
    bus.r = 4'b0011; bus.c = 4'b0111; edges(10);
    keys_off(); edges(DEBOUNCE);
    total_cnt++;
    if (bus.item_sel !== 3'd3 || bus.view_price !== 1'b1) begin
      bad_cnt++; $display("FAIL deb_bounce got sel=%0d view=%b exp sel=3 view=1", bus.item_sel, bus.view_price);
    end
  endtask

  task automatic test_qty();
    push(KEY_OK);
    total_cnt++;
    if (bus.view_quantity !== 1'b1 || bus.qty !== '0) begin
      bad_cnt++; $display("FAIL qty_enter got view=%b qty=%0d exp view=1 qty=0", bus.view_quantity, bus.qty);
    end
    push(KEY_OK);
    total_cnt++;
    if (bus.view_quantity !== 1'b1) begin bad_cnt++; $display("FAIL qty_zero_ok view_quantity got=%b exp=1", bus.view_quantity); end
    push(1); push(6);
    total_cnt++;
    if (bus.qty !== 4'd1) begin bad_cnt++; $display("FAIL qty_drop got=%0d exp=1", bus.qty); end
    push(KEY_CANCEL);
    total_cnt++;
    if (bus.view_quantity !== 1'b0 || bus.qty !== '0 || bus.item_sel !== 3'd3) begin
      bad_cnt++; $display("FAIL qty_cancel got view=%b qty=%0d sel=%0d exp 0/0/3", bus.view_quantity, bus.qty, bus.item_sel);
    end
    push(3); push(KEY_OK); push(1); push(2);
    total_cnt++;
    if (bus.qty !== 4'd12) begin bad_cnt++; $display("FAIL qty_12 got=%0d exp=12", bus.qty); end
    push(KEY_OK);
    total_cnt++;
    if (bus.view_price_q !== 1'b1 || bus.total !== 12'd300) begin
      bad_cnt++; $display("FAIL qty_total got view=%b total=%0d exp view=1 total=300", bus.view_price_q, bus.total);
    end
  endtask

  task automatic test_pay();
    push(KEY_OK);
    total_cnt++;
    if (bus.entered_amount !== 1'b1 || bus.amount !== '0) begin
      bad_cnt++; $display("FAIL pay_enter got view=%b amt=%0d exp view=1 amt=0", bus.entered_amount, bus.amount);
    end
    key_on(1); edges(DEBOUNCE + 1 + 20);
    total_cnt++;
    if (bus.amount !== 12'd1) begin bad_cnt++; $display("FAIL pay_hold got=%0d exp=1", bus.amount); end
    keys_off(); edges(DEBOUNCE - 1);
    key_on(1); edges(10);
    total_cnt++;
    if (bus.amount !== 12'd1) begin bad_cnt++; $display("FAIL pay_short_release got=%0d exp=1", bus.amount); end
    keys_off(); edges(DEBOUNCE);
    push(1);
    total_cnt++;
    if (bus.amount !== 12'd11) begin bad_cnt++; $display("FAIL pay_repress got=%0d exp=11", bus.amount); end
    push(KEY_CANCEL);
    goto_pay();
    push(2); push(9); push(9);
    key_on(KEY_OK); edges(DEBOUNCE + 1);
    total_cnt++;
    if (bus.short !== 1'b1 || bus.entered_amount !== 1'b1 || bus.amount !== 12'd299) begin
      bad_cnt++; $display("FAIL pay_short got short=%b view=%b amt=%0d exp 1/1/299", bus.short, bus.entered_amount, bus.amount);
    end
    edges(1);
    total_cnt++;
    if (bus.short !== 1'b0 || bus.entered_amount !== 1'b1) begin
      bad_cnt++; $display("FAIL pay_short_len got short=%b view=%b exp 0/1", bus.short, bus.entered_amount);
    end
    keys_off(); edges(DEBOUNCE);
    push(3);
    key_on(KEY_OK); edges(DEBOUNCE + 1);
    total_cnt++;
    if (bus.vend !== 1'b1 || bus.refund !== 1'b0 || bus.change !== 12'd2693) begin
      bad_cnt++; $display("FAIL pay_vend got vend=%b refund=%b chg=%0d exp 1/0/2693", bus.vend, bus.refund, bus.change);
    end
    edges(1);
    total_cnt++;
    if (bus.vend !== 1'b0 || bus.entered_amount !== 1'b0 || bus.amount !== '0 || bus.total !== '0 || bus.change !== 12'd2693) begin
      bad_cnt++; $display("FAIL pay_after_vend got vend=%b view=%b amt=%0d tot=%0d chg=%0d exp 0/0/0/0/2693",
        bus.vend, bus.entered_amount, bus.amount, bus.total, bus.change);
    end
    keys_off(); edges(DEBOUNCE);
  endtask

  task automatic test_refund();
    goto_pay();
    push(5); push(0);
    key_on(KEY_CANCEL); edges(DEBOUNCE + 1);
    total_cnt++;
    if (bus.refund !== 1'b1 || bus.vend !== 1'b0 || bus.change !== 12'd50 || bus.entered_amount !== 1'b0) begin
      bad_cnt++; $display("FAIL refund_pulse got refund=%b vend=%b chg=%0d view=%b exp 1/0/50/0",
        bus.refund, bus.vend, bus.change, bus.entered_amount);
    end
    edges(1);
    total_cnt++;
    if (bus.refund !== 1'b0 || bus.vend !== 1'b0) begin
      bad_cnt++; $display("FAIL refund_len got refund=%b vend=%b exp 0/0", bus.refund, bus.vend);
    end
    keys_off(); edges(DEBOUNCE);
  endtask

  task automatic test_reset_mid();
    push(3); push(KEY_OK); push(1);
    total_cnt++;
    if (bus.view_quantity !== 1'b1 || bus.qty !== 4'd1) begin
      bad_cnt++; $display("FAIL mid_setup got view=%b qty=%0d exp 1/1", bus.view_quantity, bus.qty);
    end
    @(posedge clk); #3 reset = 1'b0; #1;
    total_cnt++;
    if (bus.view_quantity !== 1'b0 || bus.qty !== '0 || bus.vend !== 1'b0 || bus.refund !== 1'b0 || bus.item_sel !== '0) begin
      bad_cnt++; $display("FAIL mid_reset got view=%b qty=%0d vend=%b refund=%b sel=%0d exp all 0",
        bus.view_quantity, bus.qty, bus.vend, bus.refund, bus.item_sel);
    end
    edges(3);
    @(negedge clk); reset = 1'b1;
    edges(5);
    total_cnt++;
    if ({bus.view_price, bus.view_quantity, bus.vend, bus.refund, bus.short} !== 5'b0) begin
      bad_cnt++; $display("FAIL mid_after got=%b exp=00000", {bus.view_price, bus.view_quantity, bus.vend, bus.refund, bus.short});
    end
  endtask

  task automatic test_random();
    int code, sel;
    logic [3:0] exp_flags;
    for (int i = 0; i < NUM_ITEMS; i++) price_tab[i] = PRICE_W'($urandom_range(1, 255));
    reset = 1'b0; edges(2);
    @(negedge clk); reset = 1'b1; edges(DEBOUNCE + 1);
    model_idle(); m_item = 0; m_price = 0; m_change = 0;
    e_vend = 0; e_refund = 0; e_short = 0;
    for (int it = 0; it < 160; it++) begin
      sel = $urandom_range(0, 99);
      if (sel < 35) code = KEY_OK;
      else if (sel < 42) code = KEY_CANCEL;
      else if (sel < 95) code = $urandom_range(0, 9);
      else code = $urandom_range(12, ROWS * COLS - 1);
      key_on(code);
      edges(DEBOUNCE + 1);
      model_key(code);
      for (int ph = 0; ph < 2; ph++) begin
        if (ph == 1) begin model_settle(); edges(1); end
        exp_flags = {(m_phase == P_PRICE), (m_phase == P_QTY), (m_phase == P_TOTAL), (m_phase == P_PAY)};
        total_cnt++;
        if ({bus.view_price, bus.view_quantity, bus.view_price_q, bus.entered_amount} !== exp_flags) begin
          bad_cnt++; $display("FAIL rnd_flags it=%0d ph=%0d key=%0d got=%b exp=%b", it, ph, code,
            {bus.view_price, bus.view_quantity, bus.view_price_q, bus.entered_amount}, exp_flags);
        end
        total_cnt++;
        if ({bus.vend, bus.refund, bus.short} !== {e_vend, e_refund, e_short}) begin
          bad_cnt++; $display("FAIL rnd_pulses it=%0d ph=%0d got=%b exp=%b", it, ph,
            {bus.vend, bus.refund, bus.short}, {e_vend, e_refund, e_short});
        end
        total_cnt++;
        if (bus.item_sel !== SEL_W'(m_item) || bus.qty !== QTY_W'(m_qty)) begin
          bad_cnt++; $display("FAIL rnd_sel_qty it=%0d ph=%0d got sel=%0d qty=%0d exp sel=%0d qty=%0d",
            it, ph, bus.item_sel, bus.qty, m_item, m_qty);
        end
        total_cnt++;
        if (bus.total !== AMT_W'(m_total) || bus.amount !== AMT_W'(m_amount) || bus.change !== AMT_W'(m_change)) begin
          bad_cnt++; $display("FAIL rnd_money it=%0d ph=%0d got tot=%0d amt=%0d chg=%0d exp tot=%0d amt=%0d chg=%0d",
            it, ph, bus.total, bus.amount, bus.change, m_total, m_amount, m_change);
        end
      end
      edges($urandom_range(0, 3));
      keys_off();
      edges($urandom_range(DEBOUNCE, DEBOUNCE + 2));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total_cnt, bad_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_debounce();
    test_qty();
    test_pay();
    test_refund();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule
